// File: rtl/hamming_link_pkg.sv
// Shared constants and state type for the Hamming link transmit path.
package hamming_link_pkg;

    localparam logic [7:0]  FRAME_HEAD = 8'h7E;
    localparam int          HEAD_LEN   = 8;
    localparam int          CW_W       = 7;
    localparam int          SLOTS      = 8;
    localparam int          FRAME_LEN  = HEAD_LEN + SLOTS * CW_W;
    localparam logic [CW_W-1:0] FILL_CW = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        SLOT = 2'd2
    } tx_state_t;

endpackage

// File: rtl/frame_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [PTR_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic [PTR_W-1:0]   next_ptr,
    output logic               any
);

    always_comb begin
        int idx;
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        next_ptr  = ptr;
        any       = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any && valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
                next_ptr   = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Frame builder and slot arbiter for the Hamming link: 0x7E head plus 8 seven-bit slots.
// Optional statistics counters (frame_cnt, fill_cnt) when FRAME_TX_STATS_EN is defined.
module frame_tx_scheduler
    import hamming_link_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_out,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*CW_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       data_out,
    output logic                       frame_start,
    output logic                       slot_valid,
    output logic [$clog2(NUM_REQ)-1:0] slot_owner,
    output logic                       busy
`ifdef FRAME_TX_STATS_EN
    ,
    output logic [15:0]                frame_cnt,
    output logic [15:0]                fill_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [5:0] LAST_HEAD_BIT = 6'(HEAD_LEN - 1);
    localparam logic [5:0] LAST_BIT      = 6'(FRAME_LEN - 1);

    tx_state_t        state;
    logic [5:0]       bit_cnt;
    logic [2:0]       slot_pos;
    logic [7:0]       shreg;
    logic [PTR_W-1:0] rr_ptr;

    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic               any_valid;
    logic               arb_en;
    logic               last_bit;
    logic               start_frame;
    logic [CW_W-1:0]    sel_cw;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .ptr       (rr_ptr),
        .valid     (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .next_ptr  (next_ptr),
        .any       (any_valid)
    );

    // Arbitrate on the last bit of the head and of every slot except the final one.
    assign arb_en = ((state == HEAD) && (bit_cnt == LAST_HEAD_BIT)) ||
                    ((state == SLOT) && (slot_pos == 3'd6) && (bit_cnt != LAST_BIT));
    assign last_bit    = (state == SLOT) && (bit_cnt == LAST_BIT);
    assign start_frame = enable && ((state == IDLE) || last_bit);
    assign req_ready   = arb_en ? grant : '0;
    assign sel_cw      = any_valid ? req_data[int'(grant_idx)*CW_W +: CW_W] : FILL_CW;
    assign busy        = (state != IDLE);
    // The head and codewords share one 8-bit shifter; its MSB is the line bit.
    assign data_out    = shreg[7];

    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            slot_pos    <= '0;
            shreg       <= '0;
            rr_ptr      <= '0;
            frame_start <= 1'b0;
            slot_valid  <= 1'b0;
            slot_owner  <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            frame_start <= start_frame;
            if (start_frame) begin
                state      <= HEAD;
                bit_cnt    <= '0;
                slot_pos   <= '0;
                shreg      <= FRAME_HEAD;
                slot_valid <= 1'b0;
                slot_owner <= '0;
            end else if ((state == IDLE) || last_bit) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                slot_pos   <= '0;
                shreg      <= '0;
                slot_valid <= 1'b0;
                slot_owner <= '0;
            end else begin
                bit_cnt <= bit_cnt + 6'd1;
                if (arb_en) begin
                    state      <= SLOT;
                    shreg      <= {sel_cw, 1'b0};
                    slot_pos   <= '0;
                    slot_valid <= any_valid;
                    slot_owner <= any_valid ? grant_idx : '0;
                    if (any_valid) rr_ptr <= next_ptr;
                end else begin
                    shreg <= {shreg[6:0], 1'b0};
                    if (state == SLOT) slot_pos <= slot_pos + 3'd1;
                end
            end
        end
    end

`ifdef FRAME_TX_STATS_EN
    always_ff @(posedge clk_out or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            fill_cnt  <= '0;
        end else begin
            if (start_frame) frame_cnt <= frame_cnt + 16'd1;
            // Filler count saturates rather than wrapping.
            if (arb_en && !any_valid && (fill_cnt != 16'hFFFF)) fill_cnt <= fill_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Scoreboard bench for frame_tx_scheduler; checks stats ports when FRAME_TX_STATS_EN is defined.
module tb_frame_tx_scheduler;
    import hamming_link_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;

    logic                    clk_out = 1'b0;
    logic                    rst     = 1'b1;
    logic                    enable  = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*CW_W-1:0] req_data  = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    data_out;
    logic                    frame_start;
    logic                    slot_valid;
    logic [PTR_W-1:0]        slot_owner;
    logic                    busy;
`ifdef FRAME_TX_STATS_EN
    logic [15:0]             frame_cnt;
    logic [15:0]             fill_cnt;
`endif

    frame_tx_scheduler #(.NUM_REQ(NUM_REQ)) dut (
        .clk_out     (clk_out),
        .rst         (rst),
        .enable      (enable),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .data_out    (data_out),
        .frame_start (frame_start),
        .slot_valid  (slot_valid),
        .slot_owner  (slot_owner),
        .busy        (busy)
`ifdef FRAME_TX_STATS_EN
        ,
        .frame_cnt   (frame_cnt),
        .fill_cnt    (fill_cnt)
`endif
    );

    always #5 clk_out = ~clk_out;

    typedef struct packed {
        logic [63:0]              bits;
        logic [63:0]              valid;
        logic [63:0]              fs;
        logic [63:0]              busy;
        logic [63:0][PTR_W-1:0]   owner;
        logic [63:0][NUM_REQ-1:0] ready;
    } frame_t;

    frame_t          exp_q[$];
    logic [CW_W-1:0] bfm_q[NUM_REQ][$];
    logic [CW_W-1:0] model_q[NUM_REQ][$];
    int              m_ptr    = 0;
    int              m_frames = 0;
    int              m_fills  = 0;
    int              last_owner[SLOTS];
    logic            last_valid[SLOTS];
    logic [CW_W-1:0] last_cw[SLOTS];
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push_cw(input int r, input logic [CW_W-1:0] cw);
        bfm_q[r].push_back(cw);
        model_q[r].push_back(cw);
    endtask

    // Reference: whole frame from queue contents and a round-robin pointer.
    task automatic issue_frame();
        frame_t          e;
        logic [7:0]      head;
        logic [CW_W-1:0] cw;
        int              found;
        int              i;
        e    = '0;
        head = FRAME_HEAD;
        e.fs[0] = 1'b1;
        e.busy  = '1;
        for (int b = 0; b < 8; b++) e.bits[b] = head[7-b];
        for (int k = 0; k < SLOTS; k++) begin
            found = -1;
            for (int off = 0; off < NUM_REQ; off++) begin
                i = (m_ptr + off) % NUM_REQ;
                if (found < 0 && model_q[i].size() > 0) found = i;
            end
            if (found >= 0) begin
                cw    = model_q[found].pop_front();
                m_ptr = (found + 1) % NUM_REQ;
                e.ready[7 + 7*k][found] = 1'b1;
            end else begin
                cw = '0;
                m_fills++;
            end
            last_owner[k] = (found >= 0) ? found : 0;
            last_valid[k] = (found >= 0);
            last_cw[k]    = cw;
            for (int j = 0; j < CW_W; j++) begin
                e.bits [8 + 7*k + j] = cw[CW_W-1-j];
                e.valid[8 + 7*k + j] = (found >= 0);
                e.owner[8 + 7*k + j] = PTR_W'(last_owner[k]);
            end
        end
        m_frames++;
        exp_q.push_back(e);
    endtask

    // Reset at frame bit b: grants issued at bits >= b never happened.
    task automatic abort_frame(input int b);
        for (int k = SLOTS - 1; k >= 0; k--)
            if ((7 + 7*k) >= b && last_valid[k]) model_q[last_owner[k]].push_front(last_cw[k]);
        m_ptr    = 0;
        m_frames = 0;
        m_fills  = 0;
    endtask

    task automatic stimulate(input int mode);
        int n;
        case (mode)
            1: for (int j = 0; j < SLOTS; j++) push_cw(2, 7'b1010101);
            2: for (int j = 0; j < 2; j++)
                   for (int r = 0; r < NUM_REQ; r++) push_cw(r, 7'(8'h11 * (r + 1)));
            3: for (int r = 0; r < NUM_REQ; r++) begin
                   n = $urandom_range(0, 2);
                   for (int j = 0; j < n; j++) push_cw(r, 7'($urandom));
               end
            default: ;
        endcase
    endtask

    task automatic check_stats();
`ifdef FRAME_TX_STATS_EN
        check("frame_cnt", 256'(frame_cnt), 256'(m_frames));
        check("fill_cnt",  256'(fill_cnt),  256'(m_fills));
`endif
    endtask

    // Called at posedge+1 with the DUT idle; returns in an idle cycle.
    task automatic run_frames(input int n, input int mode);
        enable = 1'b1;
        @(posedge clk_out); #1;
        for (int f = 0; f < n; f++) begin
            stimulate(mode);
            issue_frame();
            if (f == n - 1) begin
                repeat (20) @(posedge clk_out);
                #1 enable = 1'b0;
                repeat (44) @(posedge clk_out);
                #1;
            end else begin
                repeat (64) @(posedge clk_out);
                #1;
            end
        end
        repeat (3) @(posedge clk_out);
        #1;
        check_stats();
    endtask

    task automatic reset_test(input int b);
        for (int j = 0; j < 12; j++) push_cw(1, 7'($urandom));
        enable = 1'b1;
        @(posedge clk_out); #1;
        issue_frame();
        repeat (b) @(posedge clk_out);
        #1;
        rst    = 1'b1;
        enable = 1'b0;
        abort_frame(b);
        repeat (2) @(posedge clk_out);
        #1 rst = 1'b0;
        check_stats();
        for (int j = 0; j < 2; j++) push_cw(3, 7'($urandom));
        run_frames(2, 0);
    endtask

    // Requester model: pops its queue on each handshake.
    initial begin
        logic [NUM_REQ-1:0] hs;
        forever begin
            @(negedge clk_out);
            hs = req_ready & req_valid;
            @(posedge clk_out);
            #2;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (hs[r] && bfm_q[r].size() > 0) void'(bfm_q[r].pop_front());
                req_valid[r] = (bfm_q[r].size() > 0);
                if (bfm_q[r].size() > 0) req_data[r*CW_W +: CW_W] = bfm_q[r][0];
                else                     req_data[r*CW_W +: CW_W] = '0;
            end
        end
    end

    // Monitor: captures each frame from frame_start and compares with the scoreboard.
    initial begin
        frame_t e;
        frame_t g;
        int     idx;
        idx = -1;
        e   = '0;
        g   = '0;
        forever begin
            @(negedge clk_out);
            if (rst) begin
                check("reset_outputs", 256'({data_out, frame_start, slot_valid, slot_owner, req_ready, busy}), '0);
                idx = -1;
            end else if (idx < 0 && !frame_start) begin
                check("idle_outputs", 256'({data_out, slot_valid, slot_owner, req_ready, busy}), '0);
            end else begin
                if (idx < 0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 256'(frame_start), '0);
                    end else begin
                        e   = exp_q.pop_front();
                        g   = '0;
                        idx = 0;
                    end
                end
                if (idx >= 0) begin
                    g.bits[idx]  = data_out;
                    g.valid[idx] = slot_valid;
                    g.fs[idx]    = frame_start;
                    g.busy[idx]  = busy;
                    g.owner[idx] = slot_owner;
                    g.ready[idx] = req_ready;
                    idx++;
                    if (idx == 64) begin
                        check("frame_bits",  256'(g.bits),  256'(e.bits));
                        check("slot_valid",  256'(g.valid), 256'(e.valid));
                        check("frame_start", 256'(g.fs),    256'(e.fs));
                        check("busy",        256'(g.busy),  256'(e.busy));
                        check("slot_owner",  256'(g.owner), 256'(e.owner));
                        check("req_ready",   256'(g.ready), 256'(e.ready));
                        idx = -1;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk_out);
        #1 rst = 1'b0;
        @(posedge clk_out); #1;
        run_frames(3, 0);
        run_frames(2, 2);
        run_frames(1, 1);
        run_frames(6, 3);
        run_frames(4, 0);
        reset_test(30);
        reset_test(28);
        run_frames(5, 3);
        run_frames(4, 0);
        repeat (5) @(posedge clk_out);
        #1;
        check("frames_pending", 256'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
